// File: rtl/clk_run_ctrl_if.sv
// Command/configuration channels between the host/UI logic and clk_run_ctrl.
//
// Handshake rule for both channels: the master holds *_valid and its payload
// stable while waiting; a transfer happens on the clkin rising edge where
// *_valid and *_ready are both high. The slave never waits on *_valid
// before raising *_ready.
interface clk_run_ctrl_if #(
  parameter int CNT_W  = 32,
  parameter int STEP_W = 16
);
  logic              cfg_valid;
  logic [CNT_W-1:0]  cfg_half;
  logic              cfg_ready;
  logic              cmd_valid;
  logic [1:0]        cmd_op;
  logic [STEP_W-1:0] cmd_cnt;
  logic              cmd_ready;

  modport master (
    output cfg_valid, cfg_half, cmd_valid, cmd_op, cmd_cnt,
    input  cfg_ready, cmd_ready
  );

  modport slave (
    input  cfg_valid, cfg_half, cmd_valid, cmd_op, cmd_cnt,
    output cfg_ready, cmd_ready
  );
endinterface

// File: rtl/clk_run_ctrl.sv
// Run/stop/single-step controller for the divided emulation clock.
// clkout toggles every cur_half clkin cycles while running; it is started
// with a full low phase, stopped only at the end of a high phase (or at once
// when already low), and period changes take effect at falling edges.
module clk_run_ctrl #(
  parameter int CNT_W        = 32,
  parameter int DEFAULT_HALF = 25000,
  parameter int STEP_W       = 16
) (
  input  logic              clkin,
  input  logic              rst,
  clk_run_ctrl_if.slave     ctl,
  output logic              clkout,
  output logic              tick,
  output logic              busy,
  output logic [STEP_W-1:0] steps_left,
  output logic [CNT_W-1:0]  cur_half,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STEP     = 2'd2,
    STOPPING = 2'd3
  } state_t;

  localparam logic [1:0] OP_STOP = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cur_half_q;
  logic [CNT_W-1:0]  pend_half_q;
  logic              pend_q;
  logic              clkout_q;
  logic              tick_q;
  logic [STEP_W-1:0] steps_q;

  logic              cfg_hs, cmd_hs;
  logic              stop_cmd, run_cmd, step_cmd;
  logic              toggle, fall, rise;
  logic [CNT_W-1:0]  cfg_half_clamped;

  assign ctl.cfg_ready = ~pend_q;
  assign ctl.cmd_ready = (state_q != STOPPING);

  assign cfg_hs   = ctl.cfg_valid & ~pend_q;
  assign cmd_hs   = ctl.cmd_valid & (state_q != STOPPING);
  assign stop_cmd = cmd_hs & (ctl.cmd_op == OP_STOP);
  assign run_cmd  = cmd_hs & (ctl.cmd_op == OP_RUN);
  assign step_cmd = cmd_hs & (ctl.cmd_op == OP_STEP);

  // A zero half-period would never match the counter; treat it as 1.
  assign cfg_half_clamped = (ctl.cfg_half == '0) ? CNT_W'(1) : ctl.cfg_half;

  // cur_half_q is never 0, so the subtraction cannot wrap.
  assign toggle = (cnt_q == cur_half_q - CNT_W'(1));
  assign fall   = toggle & clkout_q;
  assign rise   = toggle & ~clkout_q;

  // Next-state selection; commands take priority over natural step completion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (run_cmd)
          state_d = RUN;
        else if (step_cmd && (ctl.cmd_cnt != '0))
          state_d = STEP;
      end
      RUN: begin
        if (stop_cmd)
          state_d = (!clkout_q || fall) ? IDLE : STOPPING;
      end
      STEP: begin
        if (stop_cmd)
          state_d = (!clkout_q || fall) ? IDLE : STOPPING;
        else if (run_cmd)
          state_d = RUN;
        else if (fall && (steps_q == STEP_W'(1)))
          state_d = IDLE;
      end
      STOPPING: begin
        if (fall)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, phase counter, clock output, step count and half-period registers.
  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      clkout_q    <= 1'b0;
      tick_q      <= 1'b0;
      steps_q     <= '0;
      cur_half_q  <= CNT_W'(DEFAULT_HALF);
      pend_half_q <= '0;
      pend_q      <= 1'b0;
    end else begin
      state_q <= state_d;

      // Parked low in IDLE; a fresh start begins with a full low phase.
      if (state_d == IDLE || state_q == IDLE) begin
        cnt_q    <= '0;
        clkout_q <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        cnt_q    <= toggle ? '0 : cnt_q + CNT_W'(1);
        clkout_q <= clkout_q ^ toggle;
        tick_q   <= rise;
      end

      if (state_d != STEP)
        steps_q <= '0;
      else if (state_q == IDLE)
        steps_q <= ctl.cmd_cnt;
      else if (fall)
        steps_q <= steps_q - STEP_W'(1);

      // Half-period changes: immediate when idle, else at the next falling
      // edge or on the way back to IDLE, whichever comes first.
      if (state_q == IDLE) begin
        if (cfg_hs)
          cur_half_q <= cfg_half_clamped;
      end else if (state_d == IDLE) begin
        if (cfg_hs)
          cur_half_q <= cfg_half_clamped;
        else if (pend_q)
          cur_half_q <= pend_half_q;
        pend_q <= 1'b0;
      end else begin
        if (fall && pend_q) begin
          cur_half_q <= pend_half_q;
          pend_q     <= 1'b0;
        end
        if (cfg_hs) begin
          pend_half_q <= cfg_half_clamped;
          pend_q      <= 1'b1;
        end
      end
    end
  end

  assign clkout      = clkout_q;
  assign tick        = tick_q;
  assign busy        = (state_q != IDLE);
  assign steps_left  = steps_q;
  assign cur_half    = cur_half_q;
  assign dbg_state_o = state_q;

endmodule
